modexp_ctrl: RTL and testbench

Sequential modular-exponentiation controller for the RSA encoder/decoder. It computes result = base^exp mod modn for W-bit operands using left-to-right square-and-multiply. Each modular reduction is a restoring shift-compare-subtract loop, with one 2W-bit magnitude comparison per cycle. One instance serves either encryption (exp = e) or decryption (exp = d) and sits between key/message registers and the output register.

---
 rtl/modexp_pkg.sv | 38 +++
 rtl/mod_cmp_ge.sv | 43 ++++
 rtl/modexp_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// ---------------------------------------------------------------------------
// modexp_pkg
// Shared definitions for the modular-exponentiation controller:
//   - default operand width and the matching product/reduction width
//   - controller state encoding
//   - helper for sizing the small step/bit counters
// ---------------------------------------------------------------------------
package modexp_pkg;

  // Operand width used when the controller is instantiated without override.
  localparam int DEFAULT_W  = 4;

  // Products and the reduction datapath need twice the operand width.
  localparam int DEFAULT_PW = 2 * DEFAULT_W;

  // Controller states:
  //   IDLE  - waiting for a start request
  //   RBASE - reducing the incoming base below the modulus
  //   SQR   - loading acc*acc into the reduction register
  //   RED   - reducing the latest product
  //   MUL   - loading acc*base into the reduction register
  //   DONE  - one-cycle result presentation
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RBASE = 3'd1,
    SQR   = 3'd2,
    RED   = 3'd3,
    MUL   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Width of a counter that has to hold W-1 down to 0. A 1-bit operand
  // would give $clog2(1) = 0, so keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mod_cmp_ge.sv
// ---------------------------------------------------------------------------
// mod_cmp_ge
// Combinational unsigned magnitude comparator: ge = (a >= b).
//
// Ports:
//   a  in  N  left operand
//   b  in  N  right operand
//   ge out 1  high when a >= b
//
// Each bit position produces a "greater here" term and an "equal here" term.
// A position wins when it is greater and every more-significant position is
// equal; the result is the OR of all winners plus the all-equal case.
// ---------------------------------------------------------------------------
module mod_cmp_ge
  import modexp_pkg::*;
#(
  parameter int N = DEFAULT_PW
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ge
);

  logic [N-1:0] gt_bit;
  logic [N-1:0] eq_bit;
  logic [N-1:0] win;

  // Per-bit greater / equal terms.
  assign gt_bit = a & ~b;
  assign eq_bit = ~(a ^ b);

  // Look-ahead priority: bit j decides only if all higher bits are equal.
  for (genvar j = 0; j < N; j++) begin : g_bit
    if (j == N - 1) begin : g_top
      assign win[j] = gt_bit[j];
    end else begin : g_rest
      assign win[j] = gt_bit[j] & (&eq_bit[N-1:j+1]);
    end
  end

  assign ge = (|win) | (&eq_bit);

endmodule

// File: rtl/modexp_ctrl.sv
// ---------------------------------------------------------------------------
// modexp_ctrl
// Sequential modular-exponentiation controller: result = base^exp mod modn,
// using left-to-right square-and-multiply. Every product is reduced by a
// restoring shift-compare-subtract loop, one 2W-bit comparison per cycle.
//
// Ports:
//   clk     in  1  system clock, rising edge
//   rst_n   in  1  synchronous active-low reset
//   start   in  1  request, honoured only while busy is low
//   base    in  W  message / ciphertext, captured with start
//   exp     in  W  exponent, captured with start
//   modn    in  W  modulus, captured with start
//   busy    out 1  high whenever the controller is not idle
//   done    out 1  one-cycle pulse when result/err are valid
//   result  out W  base^exp mod modn, held until the next completion
//   err     out 1  modulus was zero, held with result
// ---------------------------------------------------------------------------
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modn,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int PW = 2 * W;
  localparam int CW = cnt_width(W);

  // Both the reduction step counter and the exponent bit index start here.
  localparam logic [CW-1:0] K_TOP = CW'(W - 1);

  state_t        state;

  // Operands captured at start; the caller may change the inputs afterwards.
  logic [W-1:0]  base_r;
  logic [W-1:0]  exp_r;
  logic [W-1:0]  modn_r;

  // Running partial result of the exponentiation, always below modn.
  logic [W-1:0]  acc;

  // Value being reduced and the reduction / exponent-bit counters.
  logic [PW-1:0] p;
  logic [CW-1:0] k;
  logic [CW-1:0] i;

  // Set by SQR when the current exponent bit needs a multiply afterwards.
  logic          mul_pend;

  logic [PW-1:0] modn_shift;
  logic [PW-1:0] p_sub;
  logic [PW-1:0] p_red;
  logic [PW-1:0] sq_prod;
  logic [PW-1:0] mul_prod;
  logic          p_ge;

  // Reduction step datapath: compare P with modn shifted by the current step
  // count and subtract when it fits. Since P < modn*2^(k+1) on entry to each
  // step, the subtraction never underflows and P ends below modn after k = 0.
  assign modn_shift = {{W{1'b0}}, modn_r} << k;

  mod_cmp_ge #(
    .N (PW)
  ) u_cmp (
    .a  (p),
    .b  (modn_shift),
    .ge (p_ge)
  );

  assign p_sub = p - modn_shift;
  assign p_red = p_ge ? p_sub : p;

  // W x W -> 2W products; both multiplicands are already reduced below modn,
  // which keeps every product under modn*2^W for the reduction loop.
  assign sq_prod  = {{W{1'b0}}, acc} * {{W{1'b0}}, acc};
  assign mul_prod = {{W{1'b0}}, acc} * {{W{1'b0}}, base_r};

  // Controller FSM with registered busy/done/result/err. The done pulse and
  // the result are loaded on the edge that enters DONE, so they are valid
  // together for exactly the DONE cycle. busy follows the next state so it
  // is high in every non-idle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_r   <= '0;
      exp_r    <= '0;
      modn_r   <= '0;
      acc      <= '0;
      p        <= '0;
      k        <= '0;
      i        <= '0;
      mul_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            modn_r <= modn;
            busy   <= 1'b1;
            if (modn == '0) begin
              // Zero modulus: report the error straight away.
              state  <= DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
            end else begin
              // Base may exceed the modulus, so reduce it first.
              p     <= {{W{1'b0}}, base};
              k     <= K_TOP;
              state <= RBASE;
            end
          end
        end

        RBASE: begin
          p <= p_red;
          if (k == '0) begin
            base_r <= p_red[W-1:0];
            // x^0 mod 1 is 0, so the accumulator must start from 1 mod modn.
            acc    <= (modn_r == W'(1)) ? '0 : W'(1);
            i      <= K_TOP;
            state  <= SQR;
          end else begin
            k <= k - CW'(1);
          end
        end

        SQR: begin
          p        <= sq_prod;
          mul_pend <= exp_r[i];
          k        <= K_TOP;
          state    <= RED;
        end

        MUL: begin
          p        <= mul_prod;
          mul_pend <= 1'b0;
          k        <= K_TOP;
          state    <= RED;
        end

        RED: begin
          p <= p_red;
          if (k == '0) begin
            acc <= p_red[W-1:0];
            if (mul_pend) begin
              state <= MUL;
            end else if (i == '0) begin
              // Last exponent bit finished: present the result.
              state  <= DONE;
              done   <= 1'b1;
              result <= p_red[W-1:0];
              err    <= 1'b0;
            end else begin
              i     <= i - CW'(1);
              state <= SQR;
            end
          end else begin
            k <= k - CW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_modexp_ctrl
// Self-checking bench for modexp_ctrl (W = 4). Expected results come from a
// plain-arithmetic reference (repeated multiply mod n) and the completion
// cycle from the square/multiply cycle-count formula.
// ---------------------------------------------------------------------------
module tb_modexp_ctrl;

  localparam int W     = 4;
  localparam int LIMIT = 200;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] modn;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int checks;
  int passed;

  modexp_ctrl #(
    .W (W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .exp    (exp),
    .modn   (modn),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: base^exp mod modn by repeated multiplication.
  function automatic logic [W-1:0] ref_modexp(input int b, input int e, input int m);
    int r;
    r = 1 % m;
    for (int n = 0; n < e; n++) r = (r * b) % m;
    return W'(r);
  endfunction

  // Reference: cycle (start-accept = 0) in which done is high.
  function automatic int ref_latency(input int e, input int m);
    int s;
    if (m == 0) return 1;
    s = 0;
    for (int n = 0; n < W; n++) s += (W + 1) * (1 + ((e >> n) & 1));
    return W + 1 + s;
  endfunction

  // Issue one start and follow the run until done. Returns in the done
  // cycle. Optionally pulses start (with a zero modulus) during cycle glitch.
  task automatic do_op(input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic [W-1:0] m, input int glitch,
                       output logic [W-1:0] res, output logic er,
                       output int dcyc, output bit busy_ok,
                       output bit hold_ok, output bit timed_out);
    logic [W-1:0] held;
    start = 1'b1;
    base  = b;
    exp   = e;
    modn  = m;
    @(posedge clk); #1;
    start = 1'b0;
    base  = W'($urandom);
    exp   = W'($urandom);
    modn  = W'($urandom);
    held      = result;
    res       = 'x;
    er        = 1'bx;
    dcyc      = -1;
    busy_ok   = 1'b1;
    hold_ok   = 1'b1;
    timed_out = 1'b1;
    for (int c = 1; c <= LIMIT; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        res       = result;
        er        = err;
        dcyc      = c;
        timed_out = 1'b0;
        break;
      end
      if (result !== held) hold_ok = 1'b0;
      if (c == glitch) begin
        start = 1'b1;
        base  = W'($urandom);
        exp   = W'($urandom);
        modn  = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    base  = 4'd7;
    exp   = 4'd3;
    modn  = 4'd11;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (result !== 4'd0) $display("[TB] FAIL reset_result: got %0d expected 0", result); else passed++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passed++;
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_basic();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    do_op(4'd7, 4'd3, 4'd11, 0, res, er, dc, bok, hok, to);
    checks++; if (to !== 1'b0) $display("[TB] FAIL basic_timeout: no done within %0d cycles", LIMIT); else passed++;
    checks++; if (res !== 4'd2) $display("[TB] FAIL basic_result: got %0d expected 2", res); else passed++;
    checks++; if (er !== 1'b0) $display("[TB] FAIL basic_err: got %b expected 0", er); else passed++;
    checks++; if (dc !== 35) $display("[TB] FAIL basic_latency: got %0d expected 35", dc); else passed++;
    checks++; if (bok !== 1'b1) $display("[TB] FAIL basic_busy_high: got %b expected 1", bok); else passed++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_fall: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    do_op(4'd7, 4'd3, 4'd15, 0, res, er, dc, bok, hok, to);
    checks++; if (res !== 4'd13) $display("[TB] FAIL rsa_encrypt: got %0d expected 13", res); else passed++;
    @(posedge clk); #1;
    do_op(4'd13, 4'd3, 4'd15, 0, res, er, dc, bok, hok, to);
    checks++; if (to !== 1'b0) $display("[TB] FAIL rsa_decrypt_accept: second start not completed"); else passed++;
    checks++; if (res !== 4'd7) $display("[TB] FAIL rsa_decrypt: got %0d expected 7", res); else passed++;
    checks++; if (dc !== 35) $display("[TB] FAIL rsa_decrypt_latency: got %0d expected 35", dc); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_edges();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    do_op(4'd5, 4'd0, 4'd7, 0, res, er, dc, bok, hok, to);
    checks++; if (res !== 4'd1) $display("[TB] FAIL exp0_result: got %0d expected 1", res); else passed++;
    checks++; if (dc !== 25) $display("[TB] FAIL exp0_latency: got %0d expected 25", dc); else passed++;
    @(posedge clk); #1;
    do_op(4'd9, 4'd5, 4'd1, 0, res, er, dc, bok, hok, to);
    checks++; if (res !== 4'd0) $display("[TB] FAIL mod1_result: got %0d expected 0", res); else passed++;
    checks++; if (dc !== 35) $display("[TB] FAIL mod1_latency: got %0d expected 35", dc); else passed++;
    @(posedge clk); #1;
    do_op(4'd14, 4'd1, 4'd5, 0, res, er, dc, bok, hok, to);
    checks++; if (res !== 4'd4) $display("[TB] FAIL rbase_result: got %0d expected 4", res); else passed++;
    checks++; if (dc !== 30) $display("[TB] FAIL rbase_latency: got %0d expected 30", dc); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_err();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    do_op(4'd6, 4'd3, 4'd0, 0, res, er, dc, bok, hok, to);
    checks++; if (er !== 1'b1) $display("[TB] FAIL err_flag: got %b expected 1", er); else passed++;
    checks++; if (res !== 4'd0) $display("[TB] FAIL err_result: got %0d expected 0", res); else passed++;
    checks++; if (dc !== 1) $display("[TB] FAIL err_latency: got %0d expected 1", dc); else passed++;
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) $display("[TB] FAIL err_held: got %b expected 1", err); else passed++;
    do_op(4'd3, 4'd2, 4'd5, 0, res, er, dc, bok, hok, to);
    checks++; if (er !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", er); else passed++;
    checks++; if (res !== 4'd4) $display("[TB] FAIL err_next_result: got %0d expected 4", res); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    do_op(4'd7, 4'd3, 4'd11, 10, res, er, dc, bok, hok, to);
    checks++; if (res !== 4'd2) $display("[TB] FAIL busy_start_result: got %0d expected 2", res); else passed++;
    checks++; if (er !== 1'b0) $display("[TB] FAIL busy_start_err: got %b expected 0", er); else passed++;
    checks++; if (dc !== 35) $display("[TB] FAIL busy_start_latency: got %0d expected 35", dc); else passed++;
    checks++; if (hok !== 1'b1) $display("[TB] FAIL busy_start_hold: result changed before done (%b)", hok); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    bit saw_done, saw_busy;
    start = 1'b1;
    base  = 4'd7;
    exp   = 4'd15;
    modn  = 4'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", done); else passed++;
    checks++; if (result !== 4'd0) $display("[TB] FAIL midreset_result: got %0d expected 0", result); else passed++;
    checks++; if (err !== 1'b0) $display("[TB] FAIL midreset_err: got %b expected 0", err); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done !== 1'b0) saw_done = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("[TB] FAIL midreset_no_done: got %b expected 0", saw_done); else passed++;
    checks++; if (saw_busy !== 1'b0) $display("[TB] FAIL midreset_stay_idle: got %b expected 0", saw_busy); else passed++;
    do_op(4'd14, 4'd1, 4'd5, 0, res, er, dc, bok, hok, to);
    checks++; if (res !== 4'd4) $display("[TB] FAIL postreset_result: got %0d expected 4", res); else passed++;
    checks++; if (dc !== 30) $display("[TB] FAIL postreset_latency: got %0d expected 30", dc); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] res; logic er; int dc; bit bok, hok, to;
    int b, e, m;
    for (int n = 0; n < 40; n++) begin
      b = int'($urandom_range(0, 15));
      e = int'($urandom_range(0, 15));
      m = int'($urandom_range(1, 15));
      do_op(W'(b), W'(e), W'(m), 0, res, er, dc, bok, hok, to);
      checks++; if (to !== 1'b0) $display("[TB] FAIL rand_timeout: b=%0d e=%0d m=%0d", b, e, m); else passed++;
      checks++; if (res !== ref_modexp(b, e, m)) $display("[TB] FAIL rand_result: b=%0d e=%0d m=%0d got %0d expected %0d", b, e, m, res, ref_modexp(b, e, m)); else passed++;
      checks++; if (er !== 1'b0) $display("[TB] FAIL rand_err: got %b expected 0", er); else passed++;
      checks++; if (dc !== ref_latency(e, m)) $display("[TB] FAIL rand_latency: e=%0d got %0d expected %0d", e, dc, ref_latency(e, m)); else passed++;
      checks++; if (!(int'(res) < m)) $display("[TB] FAIL rand_range: got %0d expected below %0d", res, m); else passed++;
      checks++; if (bok !== 1'b1) $display("[TB] FAIL rand_busy: got %b expected 1", bok); else passed++;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL rand_idle: got %b expected 0", busy); else passed++;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    base   = '0;
    exp    = '0;
    modn   = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_edges();
    test_err();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
